// File: rtl/imem_loader.sv
// Host-side loader for the instruction cache: halts the core, writes/reads program
// words over a valid/ready command channel, then releases the core to fetch from PC 0.
module imem_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_ready,
  input  logic [ADDR_WIDTH-1:0] core_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_din,
  output logic                  imem_we,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  output logic                  core_en,
  output logic                  core_rst,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    S_HALT, S_WR, S_RD_ADDR, S_RD_DATA, S_RSP, S_RUN
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [ADDR_WIDTH:0] WMAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_cmd_err;
  logic [ADDR_WIDTH:0]   r_words;
  logic                  w_fire;
  logic                  w_is_mem_op;

  assign cmd_ready     = rst && (r_state == S_HALT || r_state == S_RUN);
  assign w_fire        = cmd_valid && cmd_ready;
  assign w_is_mem_op   = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign cmd_err       = r_cmd_err;
  assign words_written = r_words;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT: if (w_fire) begin
        case (cmd_op)
          OP_WRITE: w_next = S_WR;
          OP_READ:  w_next = S_RD_ADDR;
          OP_RUN:   w_next = S_RUN;
          default:  w_next = S_HALT;
        endcase
      end
      S_WR:      w_next = S_HALT;
      S_RD_ADDR: w_next = S_RD_DATA;
      S_RD_DATA: w_next = S_RSP;
      S_RSP:     if (rsp_ready) w_next = S_HALT;
      S_RUN:     if (w_fire && cmd_op == OP_HALT) w_next = S_HALT;
      default:   w_next = S_HALT;
    endcase
  end

  // Cache port is owned by the core fetch path only while running.
  always_comb begin
    imem_addr = r_addr;
    imem_din  = r_data;
    imem_we   = 1'b0;
    core_en   = 1'b0;
    core_rst  = 1'b1;
    if (r_state == S_RUN) begin
      imem_addr = core_pc;
      imem_din  = '0;
      core_en   = 1'b1;
      core_rst  = 1'b0;
    end else if (r_state == S_WR) begin
      imem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_HALT;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_cmd_err   <= 1'b0;
      r_words     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_HALT: if (w_fire) begin
          if (w_is_mem_op) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
          end else if (cmd_op == OP_HALT) begin
            r_cmd_err <= 1'b0;
            r_words   <= '0;
          end
        end
        S_WR: if (r_words != WMAX) r_words <= r_words + 1'b1;
        S_RD_DATA: begin
          r_rsp_data  <= imem_dout;
          r_rsp_valid <= 1'b1;
        end
        S_RSP: if (rsp_ready) r_rsp_valid <= 1'b0;
        // Memory ops while running are swallowed and flagged, never touching the cache.
        S_RUN: if (w_fire) begin
          if (w_is_mem_op) begin
            r_cmd_err <= 1'b1;
          end else if (cmd_op == OP_HALT) begin
            r_cmd_err <= 1'b0;
            r_words   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural synchronous-read cache model.
module tb_imem_loader;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic [AW-1:0] core_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_din;
  logic          imem_we;
  logic [DW-1:0] imem_dout;
  logic          core_en;
  logic          core_rst;
  logic [AW:0]   words_written;
  logic          cmd_err;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_din;
    imem_dout <= mem[imem_addr];
  end

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .core_pc(core_pc), .imem_addr(imem_addr), .imem_din(imem_din),
    .imem_we(imem_we), .imem_dout(imem_dout),
    .core_en(core_en), .core_rst(core_rst),
    .words_written(words_written), .cmd_err(cmd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present a command, wait for ready (bounded), return one cycle after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && t < 50) begin cyc(); t++; end
    chk("send_ready_wait", 64'(t < 50), 64'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; core_pc = '0;
    cyc(); cyc();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_words", words_written, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst = 1'b1; #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // single write
    send(2'b00, 9'h000, 32'h00500093);
    chk("wr_we", imem_we, 1);
    chk("wr_addr", imem_addr, 0);
    chk("wr_din", imem_din, 32'h00500093);
    chk("wr_ready_low", cmd_ready, 0);
    cyc();
    chk("wr_we_off", imem_we, 0);
    chk("wr_words", words_written, 1);
    chk("wr_ready_back", cmd_ready, 1);
    chk("wr_mem0", mem[0], 32'h00500093);

    // write then read back with stalled response; also cmd_* changes after acceptance
    send(2'b00, 9'h1FF, 32'hDEADBEEF);
    cyc();
    send(2'b01, 9'h1FF, 32'h0);
    cmd_addr = 9'h055; cmd_data = 32'h12345678; #1;
    chk("rd_k1_addr", imem_addr, 9'h1FF);
    chk("rd_k1_ready", cmd_ready, 0);
    chk("rd_k1_vld", rsp_valid, 0);
    cyc();
    chk("rd_k2_vld", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_stall_vld", rsp_valid, 1);
      chk("rd_stall_data", rsp_data, 32'hDEADBEEF);
      chk("rd_stall_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("rd_done_vld", rsp_valid, 0);
    chk("rd_done_ready", cmd_ready, 1);
    chk("rd_words", words_written, 2);

    // run, illegal write while running, halt
    core_pc = 9'h004;
    send(2'b10, 9'h0, 32'h0);
    chk("run_core_rst", core_rst, 0);
    chk("run_core_en", core_en, 1);
    chk("run_addr", imem_addr, 9'h004);
    chk("run_we", imem_we, 0);
    chk("run_din", imem_din, 0);
    send(2'b00, 9'h003, 32'hAAAA5555);
    chk("run_err", cmd_err, 1);
    chk("run_wr_we", imem_we, 0);
    chk("run_still_en", core_en, 1);
    chk("run_wr_words", words_written, 2);
    cyc();
    chk("run_wr_we2", imem_we, 0);
    send(2'b11, 9'h0, 32'h0);
    chk("halt_err", cmd_err, 0);
    chk("halt_words", words_written, 0);
    chk("halt_core_rst", core_rst, 1);
    chk("halt_core_en", core_en, 0);

    // 513 writes: saturation at 512
    for (int i = 0; i < 512; i++) send(2'b00, AW'(i), DW'(i));
    cyc();
    chk("sat_512", words_written, 512);
    chk("sat_mem1ff", mem[9'h1FF], 511);
    send(2'b00, 9'h000, 32'h0000_0201);
    chk("sat_513_we", imem_we, 1);
    chk("sat_513_addr", imem_addr, 0);
    cyc();
    chk("sat_hold", words_written, 512);
    chk("sat_mem0", mem[0], 32'h201);

    // reset lands on the WR cycle: write still reaches the cache
    send(2'b00, 9'h007, 32'h0000_0077);
    rst = 1'b0;
    cyc();
    chk("rstwr_mem7", mem[7], 32'h77);
    chk("rstwr_words", words_written, 0);
    chk("rstwr_we", imem_we, 0);
    rst = 1'b1; #1;

    // reset during RD_DATA drops the response
    send(2'b01, 9'h007, 32'h0);
    cyc();
    rst = 1'b0; #1;
    chk("rstrd_ready_low", cmd_ready, 0);
    cyc();
    chk("rstrd_vld", rsp_valid, 0);
    chk("rstrd_core_rst", core_rst, 1);
    chk("rstrd_ready_in_rst", cmd_ready, 0);
    cyc();
    rst = 1'b1; #1;
    chk("rstrd_ready_rel", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rstrd_no_vld", rsp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
